// File: rtl/wb_trace_fifo_pkg.sv
// wb_trace_fifo_pkg: trace entry layout shared by the writeback trace buffer.
// Build option: define WB_TRACE_TS_EN to append a 32-bit capture timestamp
// to every entry (101-bit entry); otherwise entries are 69 bits.
package wb_trace_fifo_pkg;

  // Field order from MSB down: pc, wnum, wdata[, ts]
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
`ifdef WB_TRACE_TS_EN
    logic [31:0] ts;
`endif
  } trace_entry_t;

`ifdef WB_TRACE_TS_EN
  localparam int TRACE_ENTRY_WD = 101;
`else
  localparam int TRACE_ENTRY_WD = 69;
`endif

endpackage

// File: rtl/wb_trace_fifo_sync.sv
// trace_sync_fifo: storage array, read/write pointers and occupancy count
// for the writeback trace buffer. Push/pop arrive already qualified by the
// parent, so this block never sees a push when full without a pop, nor a
// pop when empty. Full/empty are decided from the count by the parent.
module trace_sync_fifo
  import wb_trace_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WD    = TRACE_ENTRY_WD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [WD-1:0]           i_data,
  output logic [WD-1:0]           o_data,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_WD = PTR_W + 1;

  logic [WD-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_WD-1:0] r_count;

  // Storage write; contents need no reset because the count gates validity
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally at DEPTH; count tracks push minus pop
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_WD'(1);
        2'b01:   r_count <= r_count - CNT_WD'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Show-ahead head entry
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: captures architecturally visible register writes from the
// core writeback debug port into a FIFO drained through a valid/ready port,
// and keeps commit/drop statistics so a slow consumer never stalls the core.
// Build option: WB_TRACE_TS_EN adds a free-running cycle counter sampled
// into each entry and exported on trace_ts.
module wb_trace_fifo
  import wb_trace_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            debug_wb_pc,
  input  logic [3:0]             debug_wb_rf_we,
  input  logic [4:0]             debug_wb_rf_wnum,
  input  logic [31:0]            debug_wb_rf_wdata,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [31:0]            trace_pc,
  output logic [4:0]             trace_wnum,
  output logic [31:0]            trace_wdata,
`ifdef WB_TRACE_TS_EN
  output logic [31:0]            trace_ts,
`endif
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [31:0]            commit_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic         w_cap;
  logic         w_full;
  logic         w_pop;
  logic         w_push;
  logic         w_drop;
  trace_entry_t w_wr_entry;
  trace_entry_t w_rd_entry;

  logic             r_overflow;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [31:0]      r_commit_cnt;

  // r0 writes and non-writing instructions are invisible to the trace
  assign w_cap  = (|debug_wb_rf_we) && (debug_wb_rf_wnum != 5'd0);
  assign w_full = (fifo_count == CW'(DEPTH));
  assign trace_valid = (fifo_count != '0);
  assign w_pop  = trace_valid && trace_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts
  assign w_push = w_cap && (!w_full || w_pop);
  assign w_drop = w_cap && w_full && !w_pop;

`ifdef WB_TRACE_TS_EN
  logic [31:0] r_ts_cnt;

  // Free-running cycle counter, wraps mod 2^32
  always_ff @(posedge clk) begin
    if (reset) r_ts_cnt <= '0;
    else       r_ts_cnt <= r_ts_cnt + 32'd1;
  end
`endif

  // Assemble the entry to store from the writeback port
  always_comb begin
    w_wr_entry.pc    = debug_wb_pc;
    w_wr_entry.wnum  = debug_wb_rf_wnum;
    w_wr_entry.wdata = debug_wb_rf_wdata;
`ifdef WB_TRACE_TS_EN
    w_wr_entry.ts    = r_ts_cnt;
`endif
  end

  trace_sync_fifo #(
    .DEPTH (DEPTH),
    .WD    (TRACE_ENTRY_WD)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_wr_entry),
    .o_data  (w_rd_entry),
    .o_count (fifo_count)
  );

  assign trace_pc    = w_rd_entry.pc;
  assign trace_wnum  = w_rd_entry.wnum;
  assign trace_wdata = w_rd_entry.wdata;
`ifdef WB_TRACE_TS_EN
  assign trace_ts    = w_rd_entry.ts;
`endif

  // Statistics: commits wrap, drops saturate, overflow is sticky until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_drop_cnt   <= '0;
      r_commit_cnt <= '0;
    end else begin
      if (w_cap) r_commit_cnt <= r_commit_cnt + 32'd1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign overflow   = r_overflow;
  assign drop_cnt   = r_drop_cnt;
  assign commit_cnt = r_commit_cnt;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// tb_wb_trace_fifo: directed table vectors for capture/filter/pop behaviour,
// plus hand-written sequences for overflow, full-with-pop, wrap, reset and
// (when WB_TRACE_TS_EN is defined) timestamps.
module tb_wb_trace_fifo;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [4:0]  trace_wnum;
  logic [31:0] trace_wdata;
`ifdef WB_TRACE_TS_EN
  logic [31:0] trace_ts;
`endif
  logic [4:0]  fifo_count;
  logic        overflow;
  logic [CNT_W-1:0] drop_cnt;
  logic [31:0] commit_cnt;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  wb_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .trace_valid       (trace_valid),
    .trace_ready       (trace_ready),
    .trace_pc          (trace_pc),
    .trace_wnum        (trace_wnum),
    .trace_wdata       (trace_wdata),
`ifdef WB_TRACE_TS_EN
    .trace_ts          (trace_ts),
`endif
    .fifo_count        (fifo_count),
    .overflow          (overflow),
    .drop_cnt          (drop_cnt),
    .commit_cnt        (commit_cnt)
  );

  typedef struct {
    logic [3:0]  we;
    logic [4:0]  wnum;
    logic [31:0] pc;
    logic [31:0] wdata;
    logic        rdy;
    logic        e_valid;
    logic [4:0]  e_count;
    logic [31:0] e_commit;
    logic [31:0] e_pc;
    logic [4:0]  e_wnum;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
  endtask

  function automatic logic [31:0] g_pc(input int i);
    return 32'h1c00_1000 + 32'(i) * 32'd4;
  endfunction

  function automatic logic [4:0] g_wnum(input int i);
    return 5'((i % 31) + 1);
  endfunction

  function automatic logic [31:0] g_wdata(input int i);
    return 32'ha000_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  // One clock: drive at negedge, sample 1 time unit after the rising edge
  task automatic cyc(input logic rst, input logic [3:0] we, input logic [4:0] wnum,
                     input logic [31:0] pc, input logic [31:0] wdata, input logic rdy);
    @(negedge clk);
    reset             = rst;
    debug_wb_rf_we    = we;
    debug_wb_rf_wnum  = wnum;
    debug_wb_pc       = pc;
    debug_wb_rf_wdata = wdata;
    trace_ready       = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic cap_idx(input int i, input logic rdy);
    cyc(1'b0, 4'hf, g_wnum(i), g_pc(i), g_wdata(i), rdy);
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 4'h0, 5'd0, 32'd0, 32'd0, rdy);
  endtask

  task automatic do_reset();
    cyc(1'b1, 4'h0, 5'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic chk_head(input string nm, input int i);
    chk({nm, " valid"}, 32'(trace_valid), 32'd1);
    chk({nm, " pc"},    trace_pc, g_pc(i));
    chk({nm, " wnum"},  32'(trace_wnum), 32'(g_wnum(i)));
    chk({nm, " wdata"}, trace_wdata, g_wdata(i));
  endtask

  initial begin
    reset = 1'b1;
    debug_wb_pc = '0; debug_wb_rf_we = '0; debug_wb_rf_wnum = '0;
    debug_wb_rf_wdata = '0; trace_ready = 1'b0;

    //         we     wnum   pc            wdata         rdy  vld cnt commit  e_pc          e_wnum e_wdata
    vecs[0] = '{4'hf, 5'd0,  32'h1c000000, 32'h11111111, 1'b0, 1'b0, 5'd0, 32'd0, 32'h0,        5'd0,  32'h0};
    vecs[1] = '{4'h0, 5'd3,  32'h1c000004, 32'h22222222, 1'b0, 1'b0, 5'd0, 32'd0, 32'h0,        5'd0,  32'h0};
    vecs[2] = '{4'hf, 5'd5,  32'h1c000000, 32'h12345678, 1'b0, 1'b1, 5'd1, 32'd1, 32'h1c000000, 5'd5,  32'h12345678};
    vecs[3] = '{4'hf, 5'd6,  32'h1c000004, 32'hdeadbeef, 1'b0, 1'b1, 5'd2, 32'd2, 32'h1c000000, 5'd5,  32'h12345678};
    vecs[4] = '{4'h0, 5'd0,  32'h0,        32'h0,        1'b1, 1'b1, 5'd1, 32'd2, 32'h1c000004, 5'd6,  32'hdeadbeef};
    vecs[5] = '{4'h1, 5'd31, 32'h1c000008, 32'h000000aa, 1'b1, 1'b1, 5'd1, 32'd3, 32'h1c000008, 5'd31, 32'h000000aa};
    vecs[6] = '{4'hf, 5'd0,  32'h1c00000c, 32'h0,        1'b1, 1'b0, 5'd0, 32'd3, 32'h0,        5'd0,  32'h0};
    vecs[7] = '{4'h0, 5'd0,  32'h0,        32'h0,        1'b1, 1'b0, 5'd0, 32'd3, 32'h0,        5'd0,  32'h0};

    do_reset();
    do_reset();
    chk("reset valid",    32'(trace_valid), 32'd0);
    chk("reset count",    32'(fifo_count), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset drop",     32'(drop_cnt), 32'd0);
    chk("reset commit",   commit_cnt, 32'd0);

    // Filtering, basic capture, pop, simultaneous push/pop
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, vecs[i].we, vecs[i].wnum, vecs[i].pc, vecs[i].wdata, vecs[i].rdy);
      chk($sformatf("vec%0d valid", i),  32'(trace_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d count", i),  32'(fifo_count), 32'(vecs[i].e_count));
      chk($sformatf("vec%0d commit", i), commit_cnt, vecs[i].e_commit);
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d pc", i),    trace_pc, vecs[i].e_pc);
        chk($sformatf("vec%0d wnum", i),  32'(trace_wnum), 32'(vecs[i].e_wnum));
        chk($sformatf("vec%0d wdata", i), trace_wdata, vecs[i].e_wdata);
      end
    end
    chk("table overflow", 32'(overflow), 32'd0);
    chk("table drop",     32'(drop_cnt), 32'd0);

    // Overflow: 20 captures into 16 slots with no consumer
    do_reset();
    for (int i = 0; i < 20; i++) cap_idx(i, 1'b0);
    chk("ovf count",    32'(fifo_count), 32'd16);
    chk("ovf drop",     32'(drop_cnt), 32'd4);
    chk("ovf flag",     32'(overflow), 32'd1);
    chk("ovf commit",   commit_cnt, 32'd20);
    for (int i = 0; i < 16; i++) begin
      chk_head($sformatf("ovf drain%0d", i), i);
      idle(1'b1);
    end
    chk("ovf drained valid", 32'(trace_valid), 32'd0);
    chk("ovf sticky",        32'(overflow), 32'd1);

    // Reset with entries held clears everything, including sticky overflow
    for (int i = 0; i < 5; i++) cap_idx(i, 1'b0);
    chk("rst5 pre count", 32'(fifo_count), 32'd5);
    cyc(1'b1, 4'h0, 5'd0, 32'd0, 32'd0, 1'b1);
    chk("rst5 valid",    32'(trace_valid), 32'd0);
    chk("rst5 count",    32'(fifo_count), 32'd0);
    chk("rst5 commit",   commit_cnt, 32'd0);
    chk("rst5 drop",     32'(drop_cnt), 32'd0);
    chk("rst5 overflow", 32'(overflow), 32'd0);

    // Full with simultaneous pop: occupancy holds at DEPTH, nothing dropped
    for (int i = 0; i < 16; i++) cap_idx(i, 1'b0);
    chk("fullpop fill", 32'(fifo_count), 32'd16);
    for (int k = 0; k < 10; k++) begin
      chk_head($sformatf("fullpop head%0d", k), k);
      cap_idx(16 + k, 1'b1);
      chk($sformatf("fullpop count%0d", k), 32'(fifo_count), 32'd16);
    end
    chk("fullpop drop",     32'(drop_cnt), 32'd0);
    chk("fullpop overflow", 32'(overflow), 32'd0);
    for (int k = 10; k < 26; k++) begin
      chk_head($sformatf("fullpop drain%0d", k), k);
      idle(1'b1);
    end
    chk("fullpop empty",  32'(trace_valid), 32'd0);
    chk("fullpop commit", commit_cnt, 32'd26);

    // Streaming across pointer wrap: one push and one pop per cycle
    do_reset();
    for (int j = 0; j < 40; j++) begin
      if (j > 0) chk_head($sformatf("wrap pop%0d", j - 1), j - 1);
      cap_idx(j, 1'b1);
      chk($sformatf("wrap count%0d", j), 32'(fifo_count), 32'd1);
    end
    chk_head("wrap pop39", 39);
    idle(1'b1);
    chk("wrap empty",  32'(trace_valid), 32'd0);
    chk("wrap commit", commit_cnt, 32'd40);

`ifdef WB_TRACE_TS_EN
    // Captures at cycles 3 and 7 after reset release carry those timestamps
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c == 3 || c == 7) cap_idx(c, 1'b0);
      else idle(1'b0);
    end
    chk("ts count", 32'(fifo_count), 32'd2);
    chk("ts first", trace_ts, 32'd3);
    idle(1'b1);
    chk("ts second", trace_ts, 32'd7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
